// File: rtl/pipelined_cpu.sv
// pipelined_cpu: five-stage in-order RV32I/M subset core with local instruction and data
// memories, load-use stall, EX-stage forwarding and branch resolution in ID.

package cpu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA
  } alu_op_e;
endpackage

module pc_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)     pc_o <= '0;
    else if (en_i) pc_o <= pc_i;
endmodule

module instr_mem (
  input  logic [7:0]  addr_i,
  output logic [31:0] instr_o
);
  logic [31:0] memory [0:255];
  assign instr_o = memory[addr_i];
endmodule

module data_mem (
  input  logic        clk_i,
  input  logic [4:0]  addr_i,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o
);
  logic [7:0] memory [0:31];
  logic [4:0] w_a1, w_a2, w_a3;
  assign w_a1 = addr_i + 5'd1;
  assign w_a2 = addr_i + 5'd2;
  assign w_a3 = addr_i + 5'd3;
  always_ff @(posedge clk_i)
    if (we_i) begin
      memory[addr_i] <= wd_i[7:0];
      memory[w_a1]   <= wd_i[15:8];
      memory[w_a2]   <= wd_i[23:16];
      memory[w_a3]   <= wd_i[31:24];
    end
  assign rd_o = re_i ? {memory[w_a3], memory[w_a2], memory[w_a1], memory[addr_i]} : '0;
endmodule

module reg_file (
  input  logic        clk_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] register [0:31];
  logic        w_we;
  assign w_we = we_i && (rd_i != 5'd0);
  always_ff @(posedge clk_i)
    if (w_we) register[rd_i] <= wd_i;
  // Same-cycle write is bypassed so ID sees WB's result without an extra stage of forwarding.
  always_comb begin
    rd1_o = register[rs1_i];
    rd2_o = register[rs2_i];
    if (w_we && rd_i == rs1_i) rd1_o = wd_i;
    if (w_we && rd_i == rs2_i) rd2_o = wd_i;
    if (rs1_i == 5'd0) rd1_o = '0;
    if (rs2_i == 5'd0) rd2_o = '0;
  end
endmodule

module ifid_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] nowpc,
  output logic [31:0] instruction
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      nowpc       <= '0;
      instruction <= '0;
    end else if (hold_i) begin
      nowpc       <= nowpc;
      instruction <= instruction;
    end else if (flush_i) begin
      nowpc       <= '0;
      instruction <= '0;
    end else begin
      nowpc       <= pc_i;
      instruction <= instr_i;
    end
endmodule

module idex_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bubble_i,
  input  logic [1:0]  wb_i,
  input  logic [1:0]  m_i,
  input  logic [2:0]  ex_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] imm_i,
  input  logic [24:0] fld_i,
  output logic [1:0]  r1,
  output logic [1:0]  r2,
  output logic [2:0]  r3,
  output logic [31:0] r4,
  output logic [31:0] r5,
  output logic [31:0] r6,
  output logic [24:0] r7
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r1 <= '0; r2 <= '0; r3 <= '0;
      r4 <= '0; r5 <= '0; r6 <= '0; r7 <= '0;
    end else begin
      r1 <= bubble_i ? 2'b00  : wb_i;
      r2 <= bubble_i ? 2'b00  : m_i;
      r3 <= bubble_i ? 3'b000 : ex_i;
      r4 <= a_i;
      r5 <= b_i;
      r6 <= imm_i;
      r7 <= fld_i;
    end
endmodule

module exmem_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  wb_i,
  input  logic [1:0]  m_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] sd_i,
  input  logic [4:0]  rd_i,
  output logic [1:0]  r1,
  output logic [1:0]  r2,
  output logic [31:0] r3,
  output logic [31:0] r4,
  output logic [4:0]  r5
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r1 <= '0; r2 <= '0; r3 <= '0; r4 <= '0; r5 <= '0;
    end else begin
      r1 <= wb_i; r2 <= m_i; r3 <= alu_i; r4 <= sd_i; r5 <= rd_i;
    end
endmodule

module memwb_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  wb_i,
  input  logic [31:0] ld_i,
  input  logic [31:0] alu_i,
  input  logic [4:0]  rd_i,
  output logic [1:0]  r1,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [4:0]  r4
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r1 <= '0; r2 <= '0; r3 <= '0; r4 <= '0;
    end else begin
      r1 <= wb_i; r2 <= ld_i; r3 <= alu_i; r4 <= rd_i;
    end
endmodule

module alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] y_o
);
  always_comb begin
    y_o = a_i + b_i;
    case (op_i)
      ALU_SUB: y_o = a_i - b_i;
      ALU_MUL: y_o = a_i * b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLL: y_o = a_i << b_i[4:0];
      ALU_SRA: y_o = $signed(a_i) >>> b_i[4:0];
      default: ;
    endcase
  end
endmodule

module and_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

module hazard_unit (
  input  logic       mem_rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rrd_i,
  output logic       hazard_occur
);
  assign hazard_occur = mem_rd_i && (rrd_i != 5'd0) && (rrd_i == rs1_i || rrd_i == rs2_i);
endmodule

module pipelined_cpu
  import cpu_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  logic [31:0] w_pc, w_pc_next, w_fetch, w_ifid_pc, w_ifid_ins;
  logic        w_stall, w_take, w_br;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_regwrite, w_memtoreg, w_memread, w_memwrite, w_alusrc, w_branch;
  logic [1:0]  w_aluop;
  logic [31:0] w_imm, w_rd1, w_rd2;
  logic [1:0]  w_ex_wb, w_ex_m;
  logic [2:0]  w_ex_ctl;
  logic [31:0] w_ex_a, w_ex_b, w_ex_imm;
  logic [24:0] w_ex_fld;
  logic [6:0]  w_ex_f7;
  logic [2:0]  w_ex_f3;
  logic [4:0]  w_ex_rs1, w_ex_rs2, w_ex_rd;
  logic [1:0]  w_mem_wb, w_mem_m;
  logic [31:0] w_mem_alu, w_mem_sd, w_mem_ld;
  logic [4:0]  w_mem_rd;
  logic [1:0]  w_wb_ctl;
  logic [31:0] w_wb_ld, w_wb_alu, w_wb_data;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu_y;
  alu_op_e     w_alu_op;

  // IF
  assign w_pc_next = w_take ? (w_ifid_pc + w_imm) : (w_pc + 32'd4);
  pc_reg PC (.clk_i(clk_i), .rst_i(rst_i), .en_i(start_i & ~w_stall),
             .pc_i(w_pc_next), .pc_o(w_pc));
  instr_mem Instruction_Memory (.addr_i(w_pc[9:2]), .instr_o(w_fetch));
  ifid_reg IFIDReg (.clk_i(clk_i), .rst_i(rst_i), .hold_i(w_stall), .flush_i(w_take),
                    .pc_i(w_pc), .instr_i(w_fetch), .nowpc(w_ifid_pc), .instruction(w_ifid_ins));

  // ID
  assign w_op  = w_ifid_ins[6:0];
  assign w_rd  = w_ifid_ins[11:7];
  assign w_f3  = w_ifid_ins[14:12];
  assign w_rs1 = w_ifid_ins[19:15];
  assign w_rs2 = w_ifid_ins[24:20];
  assign w_f7  = w_ifid_ins[31:25];

  // Unsupported encodings get all-zero control so they retire as NOPs.
  always_comb begin
    w_regwrite = 1'b0; w_memtoreg = 1'b0; w_memread = 1'b0; w_memwrite = 1'b0;
    w_alusrc   = 1'b0; w_aluop    = 2'b00; w_branch = 1'b0; w_imm = '0;
    case (w_op)
      7'b0110011:
        case ({w_f7, w_f3})
          {7'b0000000, 3'b000}, {7'b0100000, 3'b000}, {7'b0000001, 3'b000},
          {7'b0000000, 3'b111}, {7'b0000000, 3'b100}, {7'b0000000, 3'b001}: begin
            w_regwrite = 1'b1; w_aluop = 2'b10;
          end
          default: ;
        endcase
      7'b0010011: begin
        w_imm = {{20{w_ifid_ins[31]}}, w_ifid_ins[31:20]};
        if (w_f3 == 3'b000 || (w_f3 == 3'b101 && w_f7 == 7'b0100000)) begin
          w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = 2'b11;
        end
      end
      7'b0000011: begin
        w_imm = {{20{w_ifid_ins[31]}}, w_ifid_ins[31:20]};
        if (w_f3 == 3'b010) begin
          w_regwrite = 1'b1; w_memtoreg = 1'b1; w_memread = 1'b1; w_alusrc = 1'b1;
        end
      end
      7'b0100011: begin
        w_imm = {{20{w_ifid_ins[31]}}, w_ifid_ins[31:25], w_ifid_ins[11:7]};
        if (w_f3 == 3'b010) begin
          w_memwrite = 1'b1; w_alusrc = 1'b1;
        end
      end
      7'b1100011: begin
        w_imm = {{19{w_ifid_ins[31]}}, w_ifid_ins[31], w_ifid_ins[7],
                 w_ifid_ins[30:25], w_ifid_ins[11:8], 1'b0};
        if (w_f3 == 3'b000) begin
          w_branch = 1'b1; w_aluop = 2'b01;
        end
      end
      default: ;
    endcase
  end

  reg_file Registers (.clk_i(clk_i), .rs1_i(w_rs1), .rs2_i(w_rs2), .rd_i(w_wb_rd),
                      .we_i(w_wb_ctl[1]), .wd_i(w_wb_data), .rd1_o(w_rd1), .rd2_o(w_rd2));
  hazard_unit Hazard (.mem_rd_i(w_ex_m[1]), .rs1_i(w_rs1), .rs2_i(w_rs2),
                      .rrd_i(w_ex_rd), .hazard_occur(w_stall));
  and_gate BranchAND (.a_i(w_branch), .b_i(w_rd1 == w_rd2), .y_o(w_br));
  // A stalled branch is re-evaluated once the bubble has passed.
  assign w_take = w_br & ~w_stall;

  idex_reg IDEXReg (.clk_i(clk_i), .rst_i(rst_i), .bubble_i(w_stall),
                    .wb_i({w_regwrite, w_memtoreg}), .m_i({w_memread, w_memwrite}),
                    .ex_i({w_alusrc, w_aluop}), .a_i(w_rd1), .b_i(w_rd2), .imm_i(w_imm),
                    .fld_i({w_f7, w_f3, w_rs1, w_rs2, w_rd}),
                    .r1(w_ex_wb), .r2(w_ex_m), .r3(w_ex_ctl), .r4(w_ex_a), .r5(w_ex_b),
                    .r6(w_ex_imm), .r7(w_ex_fld));

  // EX
  assign w_ex_f7  = w_ex_fld[24:18];
  assign w_ex_f3  = w_ex_fld[17:15];
  assign w_ex_rs1 = w_ex_fld[14:10];
  assign w_ex_rs2 = w_ex_fld[9:5];
  assign w_ex_rd  = w_ex_fld[4:0];

  always_comb begin
    w_fwd_a = w_ex_a;
    w_fwd_b = w_ex_b;
    if (w_mem_wb[1] && w_mem_rd != 5'd0 && w_mem_rd == w_ex_rs1)     w_fwd_a = w_mem_alu;
    else if (w_wb_ctl[1] && w_wb_rd != 5'd0 && w_wb_rd == w_ex_rs1) w_fwd_a = w_wb_data;
    if (w_mem_wb[1] && w_mem_rd != 5'd0 && w_mem_rd == w_ex_rs2)     w_fwd_b = w_mem_alu;
    else if (w_wb_ctl[1] && w_wb_rd != 5'd0 && w_wb_rd == w_ex_rs2) w_fwd_b = w_wb_data;
  end

  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_ex_ctl[1:0])
      2'b01: w_alu_op = ALU_SUB;
      2'b10:
        case ({w_ex_f7, w_ex_f3})
          {7'b0100000, 3'b000}: w_alu_op = ALU_SUB;
          {7'b0000001, 3'b000}: w_alu_op = ALU_MUL;
          {7'b0000000, 3'b111}: w_alu_op = ALU_AND;
          {7'b0000000, 3'b100}: w_alu_op = ALU_XOR;
          {7'b0000000, 3'b001}: w_alu_op = ALU_SLL;
          default:              w_alu_op = ALU_ADD;
        endcase
      2'b11: if (w_ex_f3 == 3'b101) w_alu_op = ALU_SRA;
      default: ;
    endcase
  end

  assign w_alu_b = w_ex_ctl[2] ? w_ex_imm : w_fwd_b;
  alu ALU (.a_i(w_fwd_a), .b_i(w_alu_b), .op_i(w_alu_op), .y_o(w_alu_y));

  exmem_reg EXMEMReg (.clk_i(clk_i), .rst_i(rst_i), .wb_i(w_ex_wb), .m_i(w_ex_m),
                      .alu_i(w_alu_y), .sd_i(w_fwd_b), .rd_i(w_ex_rd),
                      .r1(w_mem_wb), .r2(w_mem_m), .r3(w_mem_alu), .r4(w_mem_sd), .r5(w_mem_rd));

  // MEM
  data_mem Data_Memory (.clk_i(clk_i), .addr_i(w_mem_alu[4:0]), .re_i(w_mem_m[1]),
                        .we_i(w_mem_m[0]), .wd_i(w_mem_sd), .rd_o(w_mem_ld));
  memwb_reg MEMWBReg (.clk_i(clk_i), .rst_i(rst_i), .wb_i(w_mem_wb), .ld_i(w_mem_ld),
                      .alu_i(w_mem_alu), .rd_i(w_mem_rd),
                      .r1(w_wb_ctl), .r2(w_wb_ld), .r3(w_wb_alu), .r4(w_wb_rd));

  // WB
  assign w_wb_data = w_wb_ctl[0] ? w_wb_ld : w_wb_alu;
endmodule

// File: tb/tb_pipelined_cpu.sv
// Bench for pipelined_cpu: directed pipeline-timing cases plus random programs checked
// against an instruction-level model of the architectural state.
module tb_pipelined_cpu;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  int passed = 0, total = 0;

  pipelined_cpu dut (.clk_i(clk), .rst_i(rst), .start_i(start));
  always #5 clk = ~clk;

  localparam int K_ADD = 0, K_SUB = 1, K_MUL = 2, K_AND = 3, K_XOR = 4, K_SLL = 5,
                 K_ADDI = 6, K_SRAI = 7, K_LW = 8, K_SW = 9, K_BEQ = 10, K_BAD = 11;
  localparam int N = 40;

  typedef struct { int k; int rd; int rs1; int rs2; int imm; } ins_t;
  ins_t        ins [N];
  logic [31:0] prog [$];
  logic [31:0] mr [32];
  logic [7:0]  mm [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_t(input int op, input int imm, input int rs1, input int f3, input int rd);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_t(input int off, input int rs2, input int rs1);
    logic [12:0] m;
    m = 13'(off);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'b000, m[4:1], m[11], 7'b1100011};
  endfunction

  function automatic logic pipe_any();
    return |{dut.IFIDReg.nowpc, dut.IFIDReg.instruction,
             dut.IDEXReg.r1, dut.IDEXReg.r2, dut.IDEXReg.r3, dut.IDEXReg.r4,
             dut.IDEXReg.r5, dut.IDEXReg.r6, dut.IDEXReg.r7,
             dut.EXMEMReg.r1, dut.EXMEMReg.r2, dut.EXMEMReg.r3, dut.EXMEMReg.r4, dut.EXMEMReg.r5,
             dut.MEMWBReg.r1, dut.MEMWBReg.r2, dut.MEMWBReg.r3, dut.MEMWBReg.r4};
  endfunction

  // Enter reset and wipe memories/registers; caller may then preload before go().
  task automatic begin_prog();
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    prog.delete();
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      dut.Registers.register[i] = 32'h0;
      dut.Data_Memory.memory[i] = 8'h0;
    end
  endtask
  task automatic go();
    for (int i = 0; i < prog.size(); i++) dut.Instruction_Memory.memory[i] = prog[i];
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] dword(input int a);
    return {dut.Data_Memory.memory[a+3], dut.Data_Memory.memory[a+2],
            dut.Data_Memory.memory[a+1], dut.Data_Memory.memory[a]};
  endfunction

  function automatic int pick_src();
    int r;
    r = int'($urandom_range(0, 19));
    return (r < 16) ? r : r + 4;
  endfunction

  // Sequential ISA semantics over the model arrays mr/mm.
  task automatic model_run();
    int pc, guard, a;
    logic [31:0] x, y, res;
    logic [63:0] p;
    logic wr;
    pc = 0; guard = 0;
    while (pc < N && guard < 1000) begin
      guard++;
      x = mr[ins[pc].rs1]; y = mr[ins[pc].rs2]; wr = 1'b1; res = 32'h0;
      case (ins[pc].k)
        K_ADD:  res = x + y;
        K_SUB:  res = x - y;
        K_MUL:  begin p = {32'h0, x} * {32'h0, y}; res = p[31:0]; end
        K_AND:  res = x & y;
        K_XOR:  res = x ^ y;
        K_SLL:  res = x << (y % 32);
        K_ADDI: res = x + 32'(ins[pc].imm);
        K_SRAI: res = 32'($signed(x) >>> ins[pc].imm);
        K_LW: begin
          a = int'(x + 32'(ins[pc].imm));
          res = {mm[(a+3)&31], mm[(a+2)&31], mm[(a+1)&31], mm[a&31]};
        end
        K_SW: begin
          wr = 1'b0;
          a = int'(x + 32'(ins[pc].imm));
          for (int b = 0; b < 4; b++) mm[(a+b)&31] = y[8*b +: 8];
        end
        K_BEQ: begin
          wr = 1'b0;
          if (x == y) pc += ins[pc].imm / 4 - 1;
        end
        default: wr = 1'b0;
      endcase
      if (wr && ins[pc].rd != 0) mr[ins[pc].rd] = res;
      pc++;
    end
  endtask

  task automatic gen_prog();
    int k, op;
    for (int i = 0; i < N; i++) begin
      k = int'($urandom_range(0, 11));
      ins[i].k = k; ins[i].rd = int'($urandom_range(1, 15));
      ins[i].rs1 = pick_src(); ins[i].rs2 = pick_src();
      ins[i].imm = int'($urandom_range(0, 4095)) - 2048;
      case (k)
        K_ADD:  op = int'(r_t(0,  ins[i].rs2, ins[i].rs1, 0, ins[i].rd));
        K_SUB:  op = int'(r_t(32, ins[i].rs2, ins[i].rs1, 0, ins[i].rd));
        K_MUL:  op = int'(r_t(1,  ins[i].rs2, ins[i].rs1, 0, ins[i].rd));
        K_AND:  op = int'(r_t(0,  ins[i].rs2, ins[i].rs1, 7, ins[i].rd));
        K_XOR:  op = int'(r_t(0,  ins[i].rs2, ins[i].rs1, 4, ins[i].rd));
        K_SLL:  op = int'(r_t(0,  ins[i].rs2, ins[i].rs1, 1, ins[i].rd));
        K_ADDI: op = int'(i_t(7'h13, ins[i].imm, ins[i].rs1, 0, ins[i].rd));
        K_SRAI: begin
          ins[i].imm = int'($urandom_range(0, 31));
          op = int'(i_t(7'h13, 32'h400 + ins[i].imm, ins[i].rs1, 5, ins[i].rd));
        end
        K_LW:   op = int'(i_t(7'h03, ins[i].imm, ins[i].rs1, 2, ins[i].rd));
        K_SW:   op = int'(s_t(ins[i].imm, ins[i].rs2, ins[i].rs1));
        K_BEQ: begin
          // Sources come from registers the program never writes, so no ID-stage dependence.
          ins[i].rs1 = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(20, 23));
          ins[i].rs2 = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(20, 23));
          ins[i].imm = 4 * int'($urandom_range(2, 4));
          op = int'(b_t(ins[i].imm, ins[i].rs2, ins[i].rs1));
        end
        default: op = ($urandom_range(0, 1) == 0) ? int'(r_t(0, ins[i].rs2, ins[i].rs1, 2, ins[i].rd))
                                                  : int'(i_t(7'h13, 5, ins[i].rs1, 5, ins[i].rd));
      endcase
      prog.push_back(32'(op));
    end
  endtask

  initial begin
    int hz, rep;
    logic [31:0] prev, acc;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_pc", dut.PC.pc_o, 32'h0);
    chk("rst_pipe", 32'(pipe_any()), 32'h0);

    // addi x1,x0,5 lands on the 5th edge
    begin_prog();
    prog.push_back(i_t(7'h13, 5, 0, 0, 1));
    go();
    repeat (4) @(negedge clk);
    chk("t1_x1_edge4", dut.Registers.register[1], 32'h0);
    @(negedge clk);
    chk("t1_x1_edge5", dut.Registers.register[1], 32'd5);
    repeat (5) @(negedge clk);
    acc = 32'h0;
    for (int i = 2; i < 32; i++) acc |= dut.Registers.register[i];
    chk("t1_others", acc, 32'h0);

    // Back-to-back forwarding, no stall
    begin_prog();
    prog.push_back(i_t(7'h13, 3, 0, 0, 1));
    prog.push_back(r_t(0, 1, 1, 0, 2));
    prog.push_back(r_t(32, 1, 2, 0, 3));
    go();
    hz = 0;
    repeat (10) begin @(negedge clk); if (dut.Hazard.hazard_occur) hz++; end
    chk("t2_x2", dut.Registers.register[2], 32'd6);
    chk("t2_x3", dut.Registers.register[3], 32'd3);
    chk("t2_hazards", 32'(hz), 32'd0);
    chk("t2_pc", dut.PC.pc_o, 32'd40);

    // Load-use: one bubble
    begin_prog();
    dut.Data_Memory.memory[0] = 8'd5;
    prog.push_back(i_t(7'h03, 0, 0, 2, 1));
    prog.push_back(r_t(0, 1, 1, 0, 2));
    go();
    hz = 0; rep = 0; prev = dut.PC.pc_o;
    repeat (12) begin
      @(negedge clk);
      if (dut.Hazard.hazard_occur) hz++;
      if (dut.PC.pc_o == prev) rep++;
      prev = dut.PC.pc_o;
    end
    chk("t3_hazard_cycles", 32'(hz), 32'd1);
    chk("t3_pc_repeats", 32'(rep), 32'd1);
    chk("t3_x2", dut.Registers.register[2], 32'd10);
    chk("t3_pc", dut.PC.pc_o, 32'd44);

    // Taken branch flushes one slot
    begin_prog();
    prog.push_back(b_t(8, 0, 0));
    prog.push_back(i_t(7'h13, 1, 0, 0, 5));
    prog.push_back(i_t(7'h13, 2, 0, 0, 6));
    go();
    repeat (2) @(negedge clk);
    chk("t4_ifid_flush", dut.IFIDReg.instruction, 32'h0);
    chk("t4_pc_target", dut.PC.pc_o, 32'd8);
    repeat (8) @(negedge clk);
    chk("t4_x5", dut.Registers.register[5], 32'h0);
    chk("t4_x6", dut.Registers.register[6], 32'd2);

    // Store with forwarded data, then reload
    begin_prog();
    prog.push_back(i_t(7'h13, -7, 0, 0, 1));
    prog.push_back(s_t(4, 1, 0));
    prog.push_back(i_t(7'h03, 4, 0, 2, 2));
    go();
    repeat (10) @(negedge clk);
    chk("t5_mem4", dword(4), 32'hFFFF_FFF9);
    chk("t5_x2", dut.Registers.register[2], 32'hFFFF_FFF9);

    // mul/xor/sll/and/srai with x1=-16, x2=3
    begin_prog();
    dut.Registers.register[1] = 32'hFFFF_FFF0;
    dut.Registers.register[2] = 32'd3;
    prog.push_back(r_t(1, 2, 1, 0, 3));
    prog.push_back(r_t(0, 2, 1, 4, 4));
    prog.push_back(r_t(0, 2, 1, 1, 5));
    prog.push_back(r_t(0, 2, 1, 7, 6));
    prog.push_back(i_t(7'h13, 32'h402, 1, 5, 7));
    go();
    repeat (12) @(negedge clk);
    chk("t6_mul",  dut.Registers.register[3], 32'hFFFF_FFD0);
    chk("t6_xor",  dut.Registers.register[4], 32'hFFFF_FFF3);
    chk("t6_sll",  dut.Registers.register[5], 32'hFFFF_FF80);
    chk("t6_and",  dut.Registers.register[6], 32'h0);
    chk("t6_srai", dut.Registers.register[7], 32'hFFFF_FFFC);

    // Reset mid-run clears pipeline immediately, keeps registers
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_busy", 32'(pipe_any()), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_pc", dut.PC.pc_o, 32'h0);
    chk("t6_rst_pipe", 32'(pipe_any()), 32'h0);
    chk("t6_rst_keep_x3", dut.Registers.register[3], 32'hFFFF_FFD0);
    chk("t6_rst_keep_x1", dut.Registers.register[1], 32'hFFFF_FFF0);

    // Random programs against the instruction-level model
    for (int t = 0; t < 6; t++) begin
      begin_prog();
      gen_prog();
      mr[0] = 32'h0;
      for (int i = 1; i < 32; i++) mr[i] = $urandom;
      mr[21] = mr[20];
      for (int i = 0; i < 32; i++) mm[i] = 8'($urandom);
      for (int i = 0; i < 32; i++) begin
        dut.Registers.register[i] = mr[i];
        dut.Data_Memory.memory[i] = mm[i];
      end
      go();
      model_run();
      repeat (3 * N + 10) @(negedge clk);
      for (int i = 1; i < 32; i++)
        chk($sformatf("rnd%0d_x%0d", t, i), dut.Registers.register[i], mr[i]);
      for (int w = 0; w < 8; w++)
        chk($sformatf("rnd%0d_mem%0d", t, 4 * w), dword(4 * w),
            {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
